// File: rtl/aes_128_pkg.sv
// Shared constants, types and round-function helpers for the AES-128 cores.
// Byte 0 of a block is bits [127:120]; bytes fill columns first (index = row + 4*col).
package aes_128_pkg;

  localparam int AES_ROUNDS   = 10;
  localparam int ROUND_CYCLES = 3;

  typedef enum logic [1:0] {
    IDLE,
    SR,
    SB,
    MIX
  } state_e;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  col_t;
  typedef logic [127:0] block_t;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r is rotated right by r columns.
  function automatic block_t inv_shift_rows(input block_t s);
    block_t o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic col_t inv_mix_column(input col_t c);
    byte_t a  [4];
    byte_t x2 [4];
    byte_t x4 [4];
    byte_t x8 [4];
    byte_t m9 [4];
    byte_t mb [4];
    byte_t md [4];
    byte_t me [4];
    for (int unsigned i = 0; i < 4; i++) begin
      a[i]  = c[31 - 8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// One 32-bit column through the inverse S-box; four byte ROMs with registered output.
module aes_inv_sbox
  import aes_128_pkg::*;
(
  input  logic i_clk,
  input  col_t i_addr,
  output col_t o_data
);

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  col_t r_data;

  always_ff @(posedge i_clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      r_data[31 - 8*i -: 8] <= INV_SBOX[i_addr[31 - 8*i -: 8]];
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/aes_128_inv_core_3val.sv
// Iterative AES-128 inverse cipher: 10 rounds of SR -> SB -> MIX, round keys
// requested in descending order through key_ready.
module aes_128_inv_core_3val
  import aes_128_pkg::*;
(
  input  logic         clk,
  input  logic         kill,
  input  logic [127:0] in_data,
  input  logic         in_en,
  input  logic [127:0] key_round,
  output logic         key_ready,
  output logic [127:0] out_data,
  output logic         out_en,
  output logic         in_en_collision_irq_pulse
);

  state_e       r_fsm;
  logic [3:0]   r_round;
  block_t       r_state;
  block_t       r_out_data;
  logic         r_out_en;
  logic         r_irq;

  logic         w_accept;
  logic         w_collision;
  logic         w_en_mixcol;
  block_t       w_sbox_addr;
  block_t       w_sbox_q;
  block_t       w_t;
  block_t       w_mixed;

  assign w_accept    = !kill && in_en && (r_fsm == IDLE);
  assign w_collision = !kill && in_en && (r_fsm != IDLE);
  assign w_en_mixcol = (r_round != 4'(AES_ROUNDS));

  // Addresses stay stable from SR through MIX, so the registered ROM output
  // loaded during SR/SB is valid when MIX consumes it.
  assign w_sbox_addr = inv_shift_rows(r_state);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .i_clk  (clk),
      .i_addr (w_sbox_addr[127 - 32*g -: 32]),
      .o_data (w_sbox_q[127 - 32*g -: 32])
    );
  end

  assign w_t = w_sbox_q ^ key_round;

  always_comb begin
    w_mixed = w_t;
    for (int unsigned c = 0; c < 4; c++) begin
      w_mixed[127 - 32*c -: 32] = inv_mix_column(w_t[127 - 32*c -: 32]);
    end
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      r_fsm      <= IDLE;
      r_round    <= '0;
      r_state    <= '0;
      r_out_data <= '0;
      r_out_en   <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_out_en <= 1'b0;
      r_irq    <= w_collision;
      case (r_fsm)
        IDLE: begin
          if (in_en) begin
            r_state <= in_data ^ key_round;
            r_round <= 4'd1;
            r_fsm   <= SR;
          end
        end
        SR:  r_fsm <= SB;
        SB:  r_fsm <= MIX;
        MIX: begin
          if (w_en_mixcol) begin
            r_state <= w_mixed;
            r_round <= r_round + 4'd1;
            r_fsm   <= SR;
          end else begin
            r_out_data <= w_t;
            r_out_en   <= 1'b1;
            r_fsm      <= IDLE;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign key_ready                 = w_accept || (!kill && (r_fsm == MIX));
  assign out_data                  = r_out_data;
  assign out_en                    = r_out_en;
  assign in_en_collision_irq_pulse = r_irq;

endmodule

// File: tb/tb_aes_128_inv_core_3val.sv
// Bench for the AES-128 inverse core: FIPS vectors, back-to-back, collision,
// kill, and randomized blocks against a byte-level reference decryptor.
module tb_aes_128_inv_core_3val;
  import aes_128_pkg::*;

  localparam int LAT = 1 + AES_ROUNDS * ROUND_CYCLES;

  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         kill;
  logic         in_en;
  logic [127:0] in_data;
  logic [127:0] key_round;
  logic         key_ready;
  logic [127:0] out_data;
  logic         out_en;
  logic         irq;

  always #5 clk = ~clk;

  aes_128_inv_core_3val dut (
    .clk                       (clk),
    .kill                      (kill),
    .in_data                   (in_data),
    .in_en                     (in_en),
    .key_round                 (key_round),
    .key_ready                 (key_ready),
    .out_data                  (out_data),
    .out_en                    (out_en),
    .in_en_collision_irq_pulse (irq)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  logic [127:0] rk  [11];
  int           kidx;

  logic         o_kr, o_oe, o_irq;
  logic [127:0] o_od;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic init_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] k, res;
    base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    k = round_key(key, 10);
    for (int b = 0; b < 16; b++) s[b] = ct[127 - 8*b -: 8] ^ k[127 - 8*b -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r + 4*c] = s[r + 4*((c - r + 4) % 4)];
      k = round_key(key, rnd);
      for (int b = 0; b < 16; b++) s[b] = isb[t[b]] ^ k[127 - 8*b -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(base[(j - r + 4) % 4], s[j + 4*c]);
            t[r + 4*c] = acc;
          end
        for (int b = 0; b < 16; b++) s[b] = t[b];
      end
    end
    for (int b = 0; b < 16; b++) res[127 - 8*b -: 8] = s[b];
    return res;
  endfunction

  function automatic logic [79:0] kr_rule(input int start);
    logic [79:0] m;
    m = '0;
    for (int r = 0; r <= AES_ROUNDS; r++) m[start + ROUND_CYCLES*r] = 1'b1;
    return m;
  endfunction

  task automatic set_keys(input logic [127:0] key);
    for (int r = 0; r <= AES_ROUNDS; r++) rk[r] = round_key(key, r);
    kidx = AES_ROUNDS;
  endtask

  // One cycle: drive at posedge+1, observe at negedge, advance key source on a pulse.
  task automatic step(input logic en, input logic [127:0] din, input logic kl);
    in_en     = en;
    in_data   = din;
    kill      = kl;
    key_round = rk[kidx];
    @(negedge clk);
    o_kr  = key_ready;
    o_oe  = out_en;
    o_od  = out_data;
    o_irq = irq;
    @(posedge clk);
    #1;
    if (o_kr && kidx > 0) kidx--;
    in_en = 1'b0;
    kill  = 1'b0;
  endtask

  task automatic run_block(input logic [127:0] ct, input logic [127:0] key, input int ncyc,
                           input logic [79:0] en_mask, input int kill_at,
                           output logic [79:0] kr_m, output logic [79:0] oe_m,
                           output logic [79:0] irq_m, output logic [127:0] res,
                           output logic [127:0] last_od);
    kr_m = '0; oe_m = '0; irq_m = '0; res = 'x; last_od = 'x;
    set_keys(key);
    for (int i = 0; i < ncyc; i++) begin
      step(en_mask[i], ct, (i == kill_at));
      kr_m[i]  = o_kr;
      oe_m[i]  = o_oe;
      irq_m[i] = o_irq;
      if (o_oe) res = o_od;
      last_od = o_od;
    end
  endtask

  task automatic test_reset();
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    n_total++; if (o_kr !== 1'b0) $display("FAIL reset_key_ready: got %b expected 0", o_kr); else n_pass++;
    n_total++; if (o_oe !== 1'b0) $display("FAIL reset_out_en: got %b expected 0", o_oe); else n_pass++;
    n_total++; if (o_od !== 128'h0) $display("FAIL reset_out_data: got %h expected 0", o_od); else n_pass++;
    n_total++; if (o_irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", o_irq); else n_pass++;
  endtask

  task automatic test_fips_c1();
    logic [79:0] kr_m, oe_m, irq_m; logic [127:0] res, lod;
    run_block(CT_C1, K_C1, 40, 80'b1, -1, kr_m, oe_m, irq_m, res, lod);
    n_total++; if (kr_m !== kr_rule(0)) $display("FAIL c1_key_ready_timing: got %h expected %h", kr_m, kr_rule(0)); else n_pass++;
    n_total++; if ($countones(kr_m) != 11) $display("FAIL c1_key_pulses: got %0d expected 11", $countones(kr_m)); else n_pass++;
    n_total++; if (oe_m !== (80'b1 << LAT)) $display("FAIL c1_out_en_timing: got %h expected %h", oe_m, 80'b1 << LAT); else n_pass++;
    n_total++; if (res !== PT_C1) $display("FAIL c1_out_data: got %h expected %h", res, PT_C1); else n_pass++;
    n_total++; if (irq_m !== '0) $display("FAIL c1_irq: got %h expected 0", irq_m); else n_pass++;
  endtask

  task automatic test_fips_b();
    logic [79:0] kr_m, oe_m, irq_m; logic [127:0] res, lod;
    run_block(CT_B, K_B, 40, 80'b1, -1, kr_m, oe_m, irq_m, res, lod);
    n_total++; if (oe_m !== (80'b1 << LAT)) $display("FAIL b_out_en_timing: got %h expected %h", oe_m, 80'b1 << LAT); else n_pass++;
    n_total++; if (res !== PT_B) $display("FAIL b_out_data: got %h expected %h", res, PT_B); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [79:0] kr_m, oe_m, exp_kr;
    logic [127:0] r1, r2;
    int irq_seen;
    kr_m = '0; oe_m = '0; r1 = 'x; r2 = 'x; irq_seen = 0;
    set_keys(K_C1);
    for (int i = 0; i < 66; i++) begin
      if (i == LAT) set_keys(K_B);
      step((i == 0) || (i == LAT), (i < LAT) ? CT_C1 : CT_B, 1'b0);
      kr_m[i] = o_kr;
      oe_m[i] = o_oe;
      if (o_irq) irq_seen++;
      if (o_oe && i == LAT) r1 = o_od;
      if (o_oe && i == 2*LAT) r2 = o_od;
    end
    exp_kr = kr_rule(0) | kr_rule(LAT);
    n_total++; if (oe_m !== ((80'b1 << LAT) | (80'b1 << (2*LAT)))) $display("FAIL b2b_out_en_timing: got %h", oe_m); else n_pass++;
    n_total++; if (r1 !== PT_C1) $display("FAIL b2b_first: got %h expected %h", r1, PT_C1); else n_pass++;
    n_total++; if (r2 !== PT_B) $display("FAIL b2b_second: got %h expected %h", r2, PT_B); else n_pass++;
    n_total++; if (kr_m !== exp_kr) $display("FAIL b2b_key_ready: got %h expected %h", kr_m, exp_kr); else n_pass++;
    n_total++; if (irq_seen != 0) $display("FAIL b2b_irq: got %0d pulses expected 0", irq_seen); else n_pass++;
  endtask

  task automatic test_collision();
    logic [79:0] kr_m, oe_m, irq_m, en_m, exp_irq; logic [127:0] res, lod;
    en_m    = (80'b1) | (80'b1 << 5) | (80'b1 << 30);
    exp_irq = (80'b1 << 6) | (80'b1 << 31);
    run_block(CT_C1, K_C1, 40, en_m, -1, kr_m, oe_m, irq_m, res, lod);
    n_total++; if (irq_m !== exp_irq) $display("FAIL coll_irq: got %h expected %h", irq_m, exp_irq); else n_pass++;
    n_total++; if (res !== PT_C1) $display("FAIL coll_out_data: got %h expected %h", res, PT_C1); else n_pass++;
    n_total++; if (oe_m !== (80'b1 << LAT)) $display("FAIL coll_out_en: got %h expected %h", oe_m, 80'b1 << LAT); else n_pass++;
    n_total++; if (kr_m !== kr_rule(0)) $display("FAIL coll_key_ready: got %h expected %h", kr_m, kr_rule(0)); else n_pass++;
  endtask

  task automatic test_kill();
    logic [79:0] kr_m, oe_m, irq_m; logic [127:0] res, lod;
    run_block(CT_B, K_B, 40, 80'b1, 15, kr_m, oe_m, irq_m, res, lod);
    n_total++; if (oe_m !== '0) $display("FAIL kill_out_en: got %h expected 0", oe_m); else n_pass++;
    n_total++; if (lod !== 128'h0) $display("FAIL kill_out_data: got %h expected 0", lod); else n_pass++;
    n_total++; if ((kr_m >> 16) !== '0) $display("FAIL kill_key_ready: got %h expected 0 after cycle 15", kr_m); else n_pass++;
    n_total++; if (irq_m !== '0) $display("FAIL kill_irq: got %h expected 0", irq_m); else n_pass++;
    run_block(CT_C1, K_C1, 40, 80'b1, -1, kr_m, oe_m, irq_m, res, lod);
    n_total++; if (res !== PT_C1) $display("FAIL kill_recover: got %h expected %h", res, PT_C1); else n_pass++;
    run_block(CT_C1, K_C1, 40, 80'b1, 0, kr_m, oe_m, irq_m, res, lod);
    n_total++; if (oe_m !== '0) $display("FAIL kill_with_start_out_en: got %h expected 0", oe_m); else n_pass++;
    n_total++; if (kr_m !== '0) $display("FAIL kill_with_start_key_ready: got %h expected 0", kr_m); else n_pass++;
    n_total++; if (irq_m !== '0) $display("FAIL kill_with_start_irq: got %h expected 0", irq_m); else n_pass++;
  endtask

  task automatic test_random();
    logic [79:0] kr_m, oe_m, irq_m; logic [127:0] res, lod, key, ct, exp;
    for (int n = 0; n < 1000; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom, $urandom};
      exp = ref_decrypt(ct, key);
      run_block(ct, key, LAT + 1, 80'b1, -1, kr_m, oe_m, irq_m, res, lod);
      n_total++; if (kr_m !== kr_rule(0)) $display("FAIL rand_key_ready[%0d]: got %h expected %h", n, kr_m, kr_rule(0)); else n_pass++;
      n_total++; if (oe_m !== (80'b1 << LAT)) $display("FAIL rand_out_en[%0d]: got %h expected %h", n, oe_m, 80'b1 << LAT); else n_pass++;
      n_total++; if (res !== exp) $display("FAIL rand_out_data[%0d]: got %h expected %h", n, res, exp); else n_pass++;
      n_total++; if (irq_m !== '0) $display("FAIL rand_irq[%0d]: got %h expected 0", n, irq_m); else n_pass++;
    end
  endtask

  initial begin
    kill      = 1'b1;
    in_en     = 1'b0;
    in_data   = '0;
    key_round = '0;
    for (int r = 0; r <= AES_ROUNDS; r++) rk[r] = '0;
    kidx = 0;
    init_tables();
    @(posedge clk);
    #1;
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_back_to_back();
    test_collision();
    test_kill();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
